csa_resolve_89: RTL and testbench

//  Converts carry-save (redundant) operand pairs {c,s} from the 89-bit CSA tree back into

---
 rtl/csa_resolve_89_if.sv | 24 ++
 rtl/csa_resolve_89.sv | 102 ++++++++++
 tb/tb_csa_resolve_89.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/csa_resolve_89_if.sv
// Operand/result handshake bundle for the carry-save resolver.
// master drives operands and out_ready; slave is the resolver.
interface csa_resolve_89_if #(
  parameter int WIDTH = 89
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] c_in;
  logic [WIDTH-1:0] s_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, c_in, s_in, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, c_in, s_in, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/csa_resolve_89.sv
// Chunked carry-propagate adder: resolves {c,s} carry-save pairs
// into binary, one CHUNK-bit slice per cycle.
module csa_resolve_89 #(
  parameter int WIDTH = 89,
  parameter int CHUNK = 30
) (
  input  logic            clk,
  input  logic            rst,
  csa_resolve_89_if.slave io
);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int LASTW  = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  state_t           nstate;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic [31:0]      shamt;
  logic [CHUNK-1:0] cs;
  logic [CHUNK-1:0] ss;
  logic [CHUNK:0]   add;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] ins;
  logic             last;
  logic             accept;

  assign accept = io.in_valid & io.in_ready;
  assign last   = (idx == IW'(NCHUNK - 1));

  // Slice select; bits above WIDTH shift in as zero, so the
  // last slice's carry-out lands at add[LASTW].
  always_comb begin
    shamt = 32'(idx) * 32'(CHUNK);
    cs    = CHUNK'(c_q >> shamt);
    ss    = CHUNK'(s_q >> shamt);
    add   = {1'b0, cs} + {1'b0, ss} + (CHUNK+1)'(carry);
    mask  = WIDTH'({CHUNK{1'b1}}) << shamt;
    ins   = WIDTH'(add[CHUNK-1:0]) << shamt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (accept) nstate = ADD;
      ADD:     if (last) nstate = DONE;
      DONE:    if (io.out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = (state == IDLE);
    io.out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      c_q    <= '0;
      s_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          c_q   <= io.c_in;
          s_q   <= io.s_in;
          idx   <= '0;
          carry <= 1'b0;
        end
        ADD: begin
          sum_q <= (sum_q & ~mask) | ins;
          if (last) begin
            cout_q <= add[LASTW];
            idx    <= '0;
          end else begin
            carry <= add[CHUNK];
            idx   <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.sum  = sum_q;
  assign io.cout = cout_q;
endmodule

// File: tb/tb_csa_resolve_89.sv
// Bench for csa_resolve_89: four CHUNK variants fed in lockstep,
// checked against plain wide-integer addition.
module tb_csa_resolve_89;
  localparam int W = 89;
  localparam int ND = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] c_in = '0;
  logic [W-1:0] s_in = '0;

  logic [ND-1:0] ir;
  logic [ND-1:0] ov;
  logic [ND-1:0] co;
  logic [W-1:0]  sm [ND];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic int chunk_of(int k);
    return (k == 0) ? 30 : (k == 1) ? 1 : (k == 2) ? 16 : 89;
  endfunction

  function automatic int nch(int k);
    return (W + chunk_of(k) - 1) / chunk_of(k);
  endfunction

  for (genvar k = 0; k < ND; k++) begin : g_dut
    csa_resolve_89_if #(.WIDTH(W)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.c_in      = c_in;
    assign bus.s_in      = s_in;
    assign bus.out_ready = out_ready;
    assign ir[k]         = bus.in_ready;
    assign ov[k]         = bus.out_valid;
    assign co[k]         = bus.cout;
    assign sm[k]         = bus.sum;
    csa_resolve_89 #(.WIDTH(W), .CHUNK(chunk_of(k))) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
    );
  end

  task automatic check(input string tag, input logic [W:0] obs,
                       input logic [W:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (ir != {ND{1'b1}} && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ir != {ND{1'b1}}) check("idle_timeout", W'(ir), W'({ND{1'b1}}));
  endtask

  // One operation through all variants with out_ready held high.
  task automatic run_op(input logic [W-1:0] c, input logic [W-1:0] s,
                        input logic [W-1:0] alt, input logic use_alt);
    logic [W:0] e;
    logic [ND-1:0] seen;
    int n;
    e = {1'b0, c} + {1'b0, s};
    seen = '0;
    n = 0;
    wait_idle();
    out_ready = 1'b1;
    in_valid = 1'b1;
    c_in = c;
    s_in = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    c_in = rnd();
    s_in = rnd();
    while (seen != {ND{1'b1}} && n < 200) begin
      @(negedge clk);
      n++;
      for (int k = 0; k < ND; k++) begin
        if (!seen[k] && ov[k]) begin
          seen[k] = 1'b1;
          check($sformatf("sum_d%0d", k), {co[k], sm[k]}, e);
          check($sformatf("lat_d%0d", k), (W+1)'(n), (W+1)'(nch(k) + 1));
          if (use_alt) check($sformatf("xyz_d%0d", k), {1'b0, sm[k]}, {1'b0, alt});
        end
      end
    end
    if (seen != {ND{1'b1}}) check("out_timeout", (W+1)'(seen), (W+1)'({ND{1'b1}}));
  endtask

  initial begin
    logic [W-1:0] x, y, z, cc, ss, ones;
    logic [W:0] e;
    ones = '1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", W'(ir), W'({ND{1'b1}}));
    check("rst_out_valid", W'(ov), '0);
    check("rst_sum", {co[0], sm[0]}, '0);

    run_op('0, '0, '0, 1'b0);
    run_op(W'(1), W'(30'h3fff_ffff), '0, 1'b0);
    run_op(W'(2), ones, '0, 1'b0);

    // Backpressure: result held while out_ready low.
    wait_idle();
    out_ready = 1'b0;
    e = {1'b0, W'(89'h123_4567)} + {1'b0, ones};
    in_valid = 1'b1;
    c_in = W'(89'h123_4567);
    s_in = ones;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (100) @(negedge clk);
    check("bp_all_valid", W'(ov), W'({ND{1'b1}}));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      c_in = rnd();
      s_in = rnd();
      @(negedge clk);
      check("bp_valid", W'(ov[0]), W'(1));
      check("bp_ready", W'(ir[0]), '0);
      check("bp_sum", {co[0], sm[0]}, e);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_rel_ready", W'(ir), W'({ND{1'b1}}));
    check("bp_rel_valid", W'(ov), '0);

    // Reset during ADD after the first slice.
    @(negedge clk);
    in_valid = 1'b1;
    c_in = ones;
    s_in = ones;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", W'(ov[0]), '0);
    check("mid_rst_ready", W'(ir[0]), W'(1));
    @(negedge clk);
    rst = 1'b0;
    run_op(W'(5), W'(7), '0, 1'b0);

    // Random CSA-tree outputs.
    for (int t = 0; t < 300; t++) begin
      x = rnd();
      y = rnd();
      z = rnd();
      if ($urandom_range(0, 7) == 0) x = ones;
      if ($urandom_range(0, 7) == 0) y = ones;
      ss = x ^ y ^ z;
      cc = ((x & y) | (x & z) | (y & z)) << 1;
      run_op(cc, ss, x + y + z, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
